// File: rtl/bnn_pkg.sv
// Shared definitions for the binary-neuron datapath: state encoding, sizing helper, defaults.
package bnn_pkg;

  localparam int DEFAULT_NUM_NEURONS = 8;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COUNT   = 2'd1,
    HOLD    = 2'd2,
    UNUSED  = 2'd3
  } state_t;

  // Bits needed to index 0..value-1 (value >= 2).
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/bnn_popcount_collector_if.sv
// Bit-stream in / popcount result out handshake bundle between neuron, collector and consumer.
interface bnn_popcount_collector_if
  import bnn_pkg::*;
#(
  parameter int NUM_NEURONS = DEFAULT_NUM_NEURONS,
  parameter int CNT_W       = clog2(NUM_NEURONS + 1)
);

  logic                   in_valid;
  logic                   in_bit;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [NUM_NEURONS-1:0] out_vec;
  logic [CNT_W-1:0]       out_count;
  logic                   out_fire;

  modport master (
    output in_valid, in_bit, out_ready,
    input  in_ready, out_valid, out_vec, out_count, out_fire
  );

  modport slave (
    input  in_valid, in_bit, out_ready,
    output in_ready, out_valid, out_vec, out_count, out_fire
  );

endinterface

// File: rtl/bnn_seq_popcount.sv
// Serial one-bit-per-cycle accumulator; clear has priority over step, result registered.
module bnn_seq_popcount #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             step,
  input  logic             bit_in,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (step) begin
      count <= count + CNT_W'(bit_in);
    end
  end

endmodule

// File: rtl/bnn_popcount_collector.sv
// Packs NUM_NEURONS streamed bits, popcounts them serially and holds vec/count/fire until taken.
// Result valid NUM_NEURONS cycles after the last accepted bit; in_ready low outside COLLECT or when ena=0.
module bnn_popcount_collector
  import bnn_pkg::*;
#(
  parameter int          NUM_NEURONS = DEFAULT_NUM_NEURONS,
  parameter int          CNT_W       = clog2(NUM_NEURONS + 1),
  parameter int unsigned THRESH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  bnn_popcount_collector_if.slave  bus,
  output logic                     busy
);

  localparam int IDX_W = clog2(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_NEURONS - 1);

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       cidx;
  logic [NUM_NEURONS-1:0] vec;
  logic                   fire;
  logic                   out_valid_q;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       sum;
  logic                   accept;
  logic                   last_accept;
  logic                   take;
  logic                   cnt_clr;
  logic                   cnt_step;

  assign accept      = bus.in_valid && bus.in_ready;
  assign last_accept = accept && (idx == LAST);
  assign take        = ena && (state == HOLD) && bus.out_ready;

  // The accumulator restarts on the last collected bit, on result hand-off and on illegal-state recovery.
  assign cnt_clr  = last_accept || take || (ena && (state == UNUSED));
  assign cnt_step = ena && (state == COUNT);

  assign sum = count + CNT_W'(vec[cidx]);

  bnn_seq_popcount #(
    .CNT_W (CNT_W)
  ) u_popcount (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .step   (cnt_step),
    .bit_in (vec[cidx]),
    .count  (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      idx         <= '0;
      cidx        <= '0;
      vec         <= '0;
      fire        <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (ena) begin
      case (state)
        COLLECT: begin
          if (bus.in_valid) begin
            vec[idx] <= bus.in_bit;
            if (idx == LAST) begin
              idx   <= '0;
              cidx  <= '0;
              state <= COUNT;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        COUNT: begin
          if (cidx == LAST) begin
            cidx        <= '0;
            fire        <= (32'(sum) >= THRESH);
            out_valid_q <= 1'b1;
            state       <= HOLD;
          end else begin
            cidx <= cidx + IDX_W'(1);
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            vec         <= '0;
            fire        <= 1'b0;
            out_valid_q <= 1'b0;
            state       <= COLLECT;
          end
        end
        default: begin
          state       <= COLLECT;
          idx         <= '0;
          cidx        <= '0;
          vec         <= '0;
          fire        <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == COLLECT) && ena;
  assign bus.out_valid = out_valid_q;
  assign bus.out_vec   = vec;
  assign bus.out_count = count;
  assign bus.out_fire  = fire;
  assign busy          = (state != COLLECT) || (idx != '0);

endmodule
